// File: rtl/ifu_fetch_if.sv
// ifu_fetch_if: bundle of the fetch stage's external handshakes.
//   imem_req_*/imem_addr   : request channel to instruction memory
//   imem_resp_*/imem_rdata : single-pulse read response
//   redirect_*             : PC replacement from branch/jump resolution
//   inst_*/instruction     : fetched word handed to decode
//   fetch_fault            : sticky misaligned-redirect flag
// master = fetch stage, slave = surrounding memory/decode/branch logic.
interface ifu_fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction;
  logic [31:0] inst_pc;
  logic        fetch_fault;

  modport master (
    output imem_req_valid, imem_addr, inst_valid, instruction, inst_pc, fetch_fault,
    input  imem_req_ready, imem_resp_valid, imem_rdata, redirect_valid, redirect_pc,
           inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, inst_valid, instruction, inst_pc, fetch_fault,
    output imem_req_ready, imem_resp_valid, imem_rdata, redirect_valid, redirect_pc,
           inst_ready
  );
endinterface

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch stage. Owns the PC, keeps at most one read
// outstanding to instruction memory, and holds each fetched word with its PC
// until decode accepts it. Redirects replace the PC and squash any in-flight
// or held fetch.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - ifu_fetch_if.master (memory request/response, redirect, decode)
// Parameter RESET_PC: first fetch address after reset.
// Macro IFU_ALIGN_CHECK_EN: when defined, a redirect with pc[1:0] != 0 raises
// fetch_fault and parks the stage in HALT until reset; when undefined the low
// two bits are forced to zero and fetch_fault is tied low.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input logic       clk,
  input logic       rst_n,
  ifu_fetch_if.master bus
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, HALT} state_t;

  state_t      state;
  logic [31:0] pc;
  logic        kill;
  logic [31:0] instruction_q;
  logic [31:0] inst_pc_q;
  logic        inst_valid_q;

  logic        hs;
  logic        redir;
  logic        redir_ok;
  logic        misalign;
  logic [31:0] redir_pc;

  assign hs    = (state == REQ) && bus.imem_req_ready;
  assign redir = bus.redirect_valid &&
                 ((state == REQ) || (state == WAIT) || (state == HOLD));

`ifdef IFU_ALIGN_CHECK_EN
  logic fault_q;
  assign misalign = (bus.redirect_pc[1:0] != 2'b00);
  assign redir_pc = bus.redirect_pc;
  assign bus.fetch_fault = fault_q;
`else
  assign misalign = 1'b0;
  assign redir_pc = {bus.redirect_pc[31:2], 2'b00};
  assign bus.fetch_fault = 1'b0;
`endif

  assign redir_ok = redir && !misalign;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      kill          <= 1'b0;
      instruction_q <= '0;
      inst_pc_q     <= RESET_PC;
      inst_valid_q  <= 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
      fault_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: state <= REQ;

        REQ: begin
          if (redir_ok) pc <= redir_pc;
          if (hs) begin
            state <= WAIT;
            // request left with the old PC: its data must be thrown away
            if (redir_ok) kill <= 1'b1;
          end
        end

        WAIT: begin
          if (redir_ok) begin
            pc <= redir_pc;
            if (bus.imem_resp_valid) begin
              kill  <= 1'b0;
              state <= REQ;
            end else begin
              kill  <= 1'b1;
            end
          end else if (bus.imem_resp_valid) begin
            if (kill) begin
              kill  <= 1'b0;
              state <= REQ;
            end else begin
              instruction_q <= bus.imem_rdata;
              inst_pc_q     <= pc;
              pc            <= pc + 32'd4;
              inst_valid_q  <= 1'b1;
              state         <= HOLD;
            end
          end
        end

        HOLD: begin
          if (redir_ok) pc <= redir_pc;
          if (redir_ok || bus.inst_ready) begin
            inst_valid_q <= 1'b0;
            state        <= REQ;
          end
        end

        HALT: state <= HALT;

        default: state <= IDLE;
      endcase

`ifdef IFU_ALIGN_CHECK_EN
      // overrides whatever the case above chose for this cycle
      if (redir && misalign) begin
        fault_q      <= 1'b1;
        inst_valid_q <= 1'b0;
        state        <= HALT;
      end
`endif
    end
  end

  assign bus.imem_req_valid = (state == REQ);
  assign bus.imem_addr      = pc;
  assign bus.inst_valid     = inst_valid_q;
  assign bus.instruction    = instruction_q;
  assign bus.inst_pc        = inst_pc_q;

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ifu_fetch_if bus();

  ifu_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } inst_t;

  typedef struct {
    logic [31:0] target;
    int unsigned lat;
    int unsigned hold;
    logic [31:0] exp_pc;
    logic [31:0] exp_next;
  } vec_t;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  inst_t       exp_q[$];
  vec_t        tbl[$];
  int unsigned lat = 1;
  logic        mem_ready_cfg = 1'b1;
  logic        dec_ready_cfg = 1'b1;
  logic        rd_go = 1'b0;
  logic [31:0] rd_target = '0;
  int unsigned resp_cnt = 0;
  logic [31:0] resp_addr = '0;
  logic        resp_squash = 1'b0;
  logic [31:0] exp_pc = RESET_PC;
  logic        halted = 1'b0;
  logic        hs_seen = 1'b0;
  logic [31:0] hs_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0013;
    return a ^ 32'h5A5A_3C3C;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle, entered and left at a falling edge. DUT outputs seen on
  // entry belong to the current cycle; inputs driven here act at the next
  // rising edge. Memory, decode and the expected-value model live here.
  task automatic cycle();
    logic outstanding;
    inst_t e;
    outstanding = (resp_cnt > 0);
    bus.imem_resp_valid = 1'b0;
    if (rd_go && outstanding) resp_squash = 1'b1;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        bus.imem_resp_valid = 1'b1;
        bus.imem_rdata = mem_word(resp_addr);
        if (!resp_squash) begin
          exp_q.push_back(inst_t'{word: mem_word(resp_addr), pc: resp_addr});
          exp_pc = resp_addr + 32'd4;
        end
      end
    end

    bus.imem_req_ready = mem_ready_cfg;
    hs_seen = 1'b0;
    if (bus.imem_req_valid && mem_ready_cfg) begin
      hs_seen = 1'b1;
      hs_addr = bus.imem_addr;
      if (halted) check("req_after_halt", 32'd1, 32'd0);
      else        check("req_addr", bus.imem_addr, exp_pc);
      resp_cnt    = lat;
      resp_addr   = bus.imem_addr;
      resp_squash = rd_go;
    end

    bus.inst_ready = dec_ready_cfg;
    if (bus.inst_valid) begin
      if (dec_ready_cfg) begin
        if (exp_q.size() == 0) begin
          check("inst_spurious", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("inst_word", bus.instruction, e.word);
          check("inst_pc", bus.inst_pc, e.pc);
        end
      end else if (rd_go && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
      end
    end

    bus.redirect_valid = rd_go;
    bus.redirect_pc    = rd_target;
    if (rd_go) begin
`ifdef IFU_ALIGN_CHECK_EN
      if (rd_target[1:0] != 2'b00) halted = 1'b1;
      else
`endif
      exp_pc = {rd_target[31:2], 2'b00};
    end
    rd_go = 1'b0;
    @(negedge clk);
    bus.redirect_valid  = 1'b0;
    bus.imem_resp_valid = 1'b0;
  endtask

  task automatic wait_hs();
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (hs_seen) return;
    end
    check("wait_hs_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_inst();
    for (int i = 0; i < 40; i++) begin
      if (bus.inst_valid) return;
      cycle();
    end
    check("wait_inst_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_outputs();
    check("rst_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
    check("rst_addr", bus.imem_addr, RESET_PC);
    check("rst_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
    check("rst_instruction", bus.instruction, 32'd0);
    check("rst_inst_pc", bus.inst_pc, RESET_PC);
    check("rst_fault", {31'd0, bus.fetch_fault}, 32'd0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    exp_q.delete();
    resp_squash = 1'b1;
    halted = 1'b0;
    exp_pc = RESET_PC;
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] s_word, s_pc;
    vec_t v;

    tbl.push_back('{target: 32'h8000_1000, lat: 1, hold: 0, exp_pc: 32'h8000_1000, exp_next: 32'h8000_1004});
    tbl.push_back('{target: 32'h0000_2000, lat: 2, hold: 3, exp_pc: 32'h0000_2000, exp_next: 32'h0000_2004});
    tbl.push_back('{target: 32'hFFFF_FFFC, lat: 1, hold: 1, exp_pc: 32'hFFFF_FFFC, exp_next: 32'h0000_0000});
    tbl.push_back('{target: 32'h1234_5678, lat: 3, hold: 0, exp_pc: 32'h1234_5678, exp_next: 32'h1234_567C});
`ifndef IFU_ALIGN_CHECK_EN
    tbl.push_back('{target: 32'h8000_0103, lat: 1, hold: 0, exp_pc: 32'h8000_0100, exp_next: 32'h8000_0104});
`endif

    bus.imem_req_ready = 1'b1;
    bus.imem_resp_valid = 1'b0;
    bus.imem_rdata = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.inst_ready = 1'b1;

    // reset and first fetch
    @(negedge clk);
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    check("req_before_first_edge", {31'd0, bus.imem_req_valid}, 32'd0);
    cycle();
    check("req_one_cycle_after_release", {31'd0, bus.imem_req_valid}, 32'd1);
    check("first_addr", bus.imem_addr, 32'h8000_0000);
    cycle();
    check("inst_valid_early", {31'd0, bus.inst_valid}, 32'd0);
    cycle();
    check("inst_valid_3_cycles", {31'd0, bus.inst_valid}, 32'd1);
    check("first_word", bus.instruction, 32'h0000_0013);
    wait_hs();
    check("second_addr", hs_addr, 32'h8000_0004);

    // decode stall in HOLD
    dec_ready_cfg = 1'b0;
    wait_inst();
    s_word = bus.instruction;
    s_pc   = bus.inst_pc;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("hold_word_stable", bus.instruction, s_word);
      check("hold_pc_stable", bus.inst_pc, s_pc);
      check("hold_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
    end
    dec_ready_cfg = 1'b1;
    cycle();
    check("req_after_ready", {31'd0, bus.imem_req_valid}, 32'd1);

    // redirect in WAIT, response three cycles later
    lat = 4;
    wait_hs();
    rd_go = 1'b1; rd_target = 32'h8000_0100;
    cycle();
    for (int i = 0; i < 20; i++) begin
      if (bus.imem_req_valid) break;
      check("wait_redirect_no_inst", {31'd0, bus.inst_valid}, 32'd0);
      cycle();
    end
    lat = 1;
    wait_hs();
    check("wait_redirect_addr", hs_addr, 32'h8000_0100);

    // redirect coincident with the response
    lat = 2;
    wait_hs();
    cycle();
    rd_go = 1'b1; rd_target = 32'h8000_0200;
    cycle();
    check("resp_redirect_no_inst", {31'd0, bus.inst_valid}, 32'd0);
    lat = 1;
    wait_hs();
    check("resp_redirect_addr", hs_addr, 32'h8000_0200);

    // redirect coincident with inst_ready in HOLD
    wait_inst();
    rd_go = 1'b1; rd_target = 32'h8000_0300;
    cycle();
    wait_hs();
    check("hold_redirect_addr", hs_addr, 32'h8000_0300);

    // redirect in REQ with handshake, then in REQ without handshake
    for (int i = 0; i < 20 && !bus.imem_req_valid; i++) cycle();
    rd_go = 1'b1; rd_target = 32'h8000_0400;
    cycle();
    wait_hs();
    check("req_hs_redirect_addr", hs_addr, 32'h8000_0400);
    for (int i = 0; i < 20 && !bus.imem_req_valid; i++) cycle();
    mem_ready_cfg = 1'b0;
    rd_go = 1'b1; rd_target = 32'h8000_0500;
    cycle();
    cycle();
    mem_ready_cfg = 1'b1;
    wait_hs();
    check("req_stall_redirect_addr", hs_addr, 32'h8000_0500);

    // vector table: redirect from HOLD, fetch target, then follow-on address
    for (int unsigned r = 0; r < tbl.size(); r++) begin
      v = tbl[r];
      dec_ready_cfg = 1'b0;
      wait_inst();
      rd_go = 1'b1; rd_target = v.target;
      cycle();
      lat = v.lat;
      wait_inst();
      check("tbl_inst_pc", bus.inst_pc, v.exp_pc);
      check("tbl_word", bus.instruction, mem_word(v.exp_pc));
      for (int unsigned h = 0; h < v.hold; h++) cycle();
      dec_ready_cfg = 1'b1;
      cycle();
      wait_hs();
      check("tbl_next_addr", hs_addr, v.exp_next);
    end
    lat = 1;

    // misaligned redirect
    dec_ready_cfg = 1'b0;
    wait_inst();
    rd_go = 1'b1; rd_target = 32'h8000_0102;
    cycle();
`ifdef IFU_ALIGN_CHECK_EN
    check("fault_set", {31'd0, bus.fetch_fault}, 32'd1);
    check("fault_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      check("halt_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
      cycle();
    end
    apply_reset();
    check("fault_cleared", {31'd0, bus.fetch_fault}, 32'd0);
`else
    wait_hs();
    check("misalign_forced_addr", hs_addr, 32'h8000_0100);
    check("fault_tied_low", {31'd0, bus.fetch_fault}, 32'd0);
`endif
    dec_ready_cfg = 1'b1;

    // reset in WAIT; stale response lands in REQ after release
    lat = 4;
    wait_hs();
    cycle();
    apply_reset();
    cycle();
    check("post_reset_req", {31'd0, bus.imem_req_valid}, 32'd1);
    wait_hs();
    check("post_reset_addr", hs_addr, RESET_PC);
    wait_inst();
    check("post_reset_inst_pc", bus.inst_pc, RESET_PC);
    check("post_reset_word", bus.instruction, 32'h0000_0013);
    lat = 1;
    for (int i = 0; i < 8; i++) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
